seg7_ca_scan_reader: RTL and testbench
======================================

Name: seg7_ca_scan_reader

Overview:
- Receive-side counterpart of the common-anode BCD-to-7-segment driver path.
- Samples the pins of a 4-digit multiplexed common-anode display (segment lines plus digit anode selects) and recovers the shown digits as BCD.
- Qualifies each digit against scan ghosting and assembles full frames, flagging invalid patterns and a stalled scan.
- Used for loopback self-test of display drivers and for reading legacy display-only equipment.

Parameters:
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is accepted (range 2..255).
- TIMEOUT_CYCLES, 1000000, cycles without any accepted digit before `stale` asserts (≥ STABLE_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- Segments  input  7  segment lines gfedcba, active low; asynchronous to clk.
- dp  input  1  decimal point line, active low; asynchronous.
- SEL  input  4  anode selects, active low, one-hot when legal; SEL[0] is the rightmost digit; asynchronous.
- BCD_out  output  16  digit values, 4 bits per digit, [3:0] = digit 0.
- dp_out  output  4  decimal point per digit, active high.
- blank  output  4  per-digit flag: pattern was all segments off.
- err  output  4  per-digit flag: pattern not in the decode table.
- frame_valid  output  1  single-cycle pulse when a new frame is published.
- stale  output  1  level; no digit has been accepted within TIMEOUT_CYCLES.

Behaviour:
- **Interface (already decided):** one clock `clk`; `reset` is asynchronous and active-high.
- **Reset values:** all outputs 0. Synchroniser flops, internal captures, present mask and counters also clear.
- **Synchronisation:** {SEL, dp, Segments} (12 bits) pass through a 2-flop synchroniser. All further logic uses the second stage.
- **Legality:** a sample is legal only when exactly one SEL bit is 0. An illegal sample forces the FSM to SCAN.
- **FSM, SCAN:**
  - Legal sample: latch it as the candidate, set stab_cnt=1, go to QUAL.
- **FSM, QUAL:**
  - Sample equals candidate: stab_cnt++.
  - Sample differs but is legal: reload candidate, stab_cnt=1.
  - Illegal sample: go to SCAN.
  - When stab_cnt reaches STABLE_CYCLES: accept the candidate into its digit's capture slot (value, dp, blank, err), set that slot's present bit, go to HOLD.
- **FSM, HOLD:**
  - Sample equal to candidate: stay; no re-accept.
  - Any different sample: go to SCAN in the same cycle the difference is seen.
  - A changed pattern on the same digit is re-qualified and overwrites that slot.
- **Decode table** (gfedcba, active low; anything else → value 4'hF, err=1):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
  - 1111111→value 4'hF, blank=1, err=0.
- **Frame publish:**
  - On the accept cycle that makes present==4'b1111, copy all slots to the outputs on the next edge, pulse frame_valid for 1 cycle, and clear present.
  - Same-digit repeats before the frame completes only overwrite that slot.
  - Latency from the first stable second-stage sample of the last digit to frame_valid: STABLE_CYCLES cycles.
  - Outputs hold between frames.
- **Timeout:**
  - The idle counter clears on every accept and saturates at TIMEOUT_CYCLES.
  - At saturation: stale=1 and present clears. Outputs keep their last frame.
  - stale clears on the next accept.
- **Simultaneous events:** an accept in the same cycle as saturation counts as an accept; stale stays 0.
- **Reset mid-qualification:** the partial candidate is discarded; no frame_valid is issued after reset.

Optional Feature:
- Macro: SEG7_READER_HEX_DECODE_EN.
- Defined: six extra patterns decode with err=0.
  - A=0001000→4'hA, b=0000011→4'hB, C=1000110→4'hC
  - d=0100001→4'hD, E=0000110→4'hE, F=0001110→4'hF
  - Blank still reports 4'hF with blank=1, so blank must be checked to tell blank from F.
- Not defined: these six patterns are errors (4'hF, err=1).

Test Plan:
- **Clean scan:** reset, then scan digits 3..0 showing "1234" with dp on digit 2, each held 20 cycles, STABLE_CYCLES=8 → one frame_valid pulse; BCD_out=16'h1234, dp_out=4'b0100, err=0, blank=0.
- **Ghosting:** insert a 3-cycle wrong pattern (0000000 with the next SEL) at each digit switch → no accept of 8; frame still 16'h1234; exactly one frame_valid per full scan.
- **Illegal SEL:** SEL=4'b1111 for 30 cycles, then SEL=4'b0000 for 30 cycles → no accepts and no frame_valid; a subsequent valid scan still publishes correctly.
- **Error and blank:** digit 1 shows 1111111 and digit 0 shows 0001000 → blank=4'b0010, err=4'b0001, BCD_out[7:0]=8'hFF. With SEG7_READER_HEX_DECODE_EN defined: err=0 and BCD_out[3:0]=4'hA.
- **Timeout:** TIMEOUT_CYCLES=100; after a valid frame, freeze SEL=4'b1111 → stale rises exactly 100 cycles after the last accept and BCD_out holds; resume scanning → stale falls on the first accept, and the next frame_valid requires all 4 digits.
- **Async reset mid-QUAL:** pulse reset 2 cycles into qualifying digit 3 → all outputs 0 immediately; no frame_valid until a full new scan completes.

Source files
------------

// File: rtl/seg7_ca_scan_reader.sv
// seg7_ca_scan_reader
// Reads the pins of a 4-digit multiplexed common-anode 7-segment display and
// recovers the shown digits as BCD. Each digit pattern must be seen unchanged
// for STABLE_CYCLES synchronised samples before it is accepted, which rejects
// the short ghost patterns that appear while the anodes switch. Four accepted
// digits publish one frame.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   Segments     segment lines gfedcba, active low, asynchronous
//   dp           decimal point line, active low, asynchronous
//   SEL          anode selects, active low, one-hot when legal, SEL[0] = rightmost
//   BCD_out      recovered digits, [3:0] = digit 0
//   dp_out       decimal point per digit, active high
//   blank        per digit: pattern was all segments off
//   err          per digit: pattern not in the decode table
//   frame_valid  one-cycle pulse when a new frame is published
//   stale        no digit accepted for TIMEOUT_CYCLES cycles
//
// Build option:
//   SEG7_READER_HEX_DECODE_EN  when defined, A b C d E F also decode (err=0).
//
// State | meaning
// SCAN  | waiting for a legal sample to start qualifying
// QUAL  | counting consecutive identical samples of the candidate
// HOLD  | candidate accepted; waiting for the pattern to change

module seg7_ca_scan_reader #(
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Segments,
  input  logic        dp,
  input  logic [3:0]  SEL,
  output logic [15:0] BCD_out,
  output logic [3:0]  dp_out,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_QUAL,
    ST_HOLD
  } state_t;

  // sample layout: [11:8] SEL, [7] dp, [6:0] Segments
  logic [11:0]       r_sync1;
  logic [11:0]       r_sync2;
  logic [11:0]       r_cand;
  logic [7:0]        r_stab_cnt;
  state_t            r_state;
  state_t            w_state_nxt;

  logic [15:0]       r_slot_val;
  logic [3:0]        r_slot_dp;
  logic [3:0]        r_slot_blank;
  logic [3:0]        r_slot_err;
  logic [3:0]        r_present;

  logic [15:0]       r_bcd;
  logic [3:0]        r_dp;
  logic [3:0]        r_blank;
  logic [3:0]        r_err;
  logic              r_fv;
  logic              r_stale;
  logic [IDLE_W-1:0] r_idle;

  logic              w_legal;
  logic              w_same;
  logic              w_load;
  logic              w_inc;
  logic              w_accept;
  logic [1:0]        w_digit;
  logic [3:0]        w_dec_val;
  logic              w_dec_blank;
  logic              w_dec_err;
  logic [15:0]       w_val_nxt;
  logic [3:0]        w_dp_nxt;
  logic [3:0]        w_blank_nxt;
  logic [3:0]        w_err_nxt;
  logic [3:0]        w_present_nxt;
  logic              w_publish;
  logic              w_idle_sat;
  logic              w_idle_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {SEL, dp, Segments};
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_legal = 1'b0;
    case (r_sync2[11:8])
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  assign w_same = (r_sync2 == r_cand);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_legal) begin
          w_load      = 1'b1;
          w_state_nxt = ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (!w_legal) begin
          w_state_nxt = ST_SCAN;
        end else if (w_same) begin
          // this sample is the STABLE_CYCLES-th identical one
          if (r_stab_cnt == 8'(STABLE_CYCLES - 1)) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_inc = 1'b1;
          end
        end else begin
          w_load = 1'b1;
        end
      end
      ST_HOLD: begin
        // A changed sample drops through SCAN in the same cycle, so a legal new
        // pattern is latched immediately and counts as its own first sample.
        if (!w_legal) begin
          w_state_nxt = ST_SCAN;
        end else if (!w_same) begin
          w_load      = 1'b1;
          w_state_nxt = ST_QUAL;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_SCAN;
      r_cand     <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cand     <= r_sync2;
        r_stab_cnt <= 8'd1;
      end else if (w_inc) begin
        r_stab_cnt <= r_stab_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_digit = 2'd0;
    case (r_cand[11:8])
      4'b1110: w_digit = 2'd0;
      4'b1101: w_digit = 2'd1;
      4'b1011: w_digit = 2'd2;
      4'b0111: w_digit = 2'd3;
      default: w_digit = 2'd0;
    endcase
  end

  always_comb begin
    w_dec_val   = 4'hF;
    w_dec_blank = 1'b0;
    w_dec_err   = 1'b0;
    case (r_cand[6:0])
      7'b1000000: w_dec_val = 4'h0;
      7'b1111001: w_dec_val = 4'h1;
      7'b0100100: w_dec_val = 4'h2;
      7'b0110000: w_dec_val = 4'h3;
      7'b0011001: w_dec_val = 4'h4;
      7'b0010010: w_dec_val = 4'h5;
      7'b0000010: w_dec_val = 4'h6;
      7'b1111000: w_dec_val = 4'h7;
      7'b0000000: w_dec_val = 4'h8;
      7'b0010000: w_dec_val = 4'h9;
`ifdef SEG7_READER_HEX_DECODE_EN
      7'b0001000: w_dec_val = 4'hA;
      7'b0000011: w_dec_val = 4'hB;
      7'b1000110: w_dec_val = 4'hC;
      7'b0100001: w_dec_val = 4'hD;
      7'b0000110: w_dec_val = 4'hE;
      7'b0001110: w_dec_val = 4'hF;
`endif
      7'b1111111: w_dec_blank = 1'b1;
      default:    w_dec_err   = 1'b1;
    endcase
  end

  always_comb begin
    w_val_nxt     = r_slot_val;
    w_dp_nxt      = r_slot_dp;
    w_blank_nxt   = r_slot_blank;
    w_err_nxt     = r_slot_err;
    w_present_nxt = r_present;
    if (w_accept) begin
      w_val_nxt[{w_digit, 2'b00} +: 4] = w_dec_val;
      w_dp_nxt[w_digit]                = ~r_cand[7];
      w_blank_nxt[w_digit]             = w_dec_blank;
      w_err_nxt[w_digit]               = w_dec_err;
      w_present_nxt[w_digit]           = 1'b1;
    end
  end

  assign w_publish  = w_accept && (w_present_nxt == 4'b1111);
  assign w_idle_sat = (r_idle == IDLE_W'(TIMEOUT_CYCLES));
  // an accept in the saturating cycle wins, so stale never pulses
  assign w_idle_hit = !w_accept && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_val   <= '0;
      r_slot_dp    <= '0;
      r_slot_blank <= '0;
      r_slot_err   <= '0;
      r_present    <= '0;
      r_bcd        <= '0;
      r_dp         <= '0;
      r_blank      <= '0;
      r_err        <= '0;
      r_fv         <= 1'b0;
      r_stale      <= 1'b0;
      r_idle       <= '0;
    end else begin
      r_slot_val   <= w_val_nxt;
      r_slot_dp    <= w_dp_nxt;
      r_slot_blank <= w_blank_nxt;
      r_slot_err   <= w_err_nxt;
      r_fv         <= w_publish;
      if (w_publish || w_idle_hit) begin
        r_present <= '0;
      end else begin
        r_present <= w_present_nxt;
      end
      if (w_publish) begin
        r_bcd   <= w_val_nxt;
        r_dp    <= w_dp_nxt;
        r_blank <= w_blank_nxt;
        r_err   <= w_err_nxt;
      end
      if (w_accept) begin
        r_idle  <= '0;
        r_stale <= 1'b0;
      end else begin
        if (!w_idle_sat) begin
          r_idle <= r_idle + IDLE_W'(1);
        end
        if (w_idle_hit) begin
          r_stale <= 1'b1;
        end
      end
    end
  end

  assign BCD_out     = r_bcd;
  assign dp_out      = r_dp;
  assign blank       = r_blank;
  assign err         = r_err;
  assign frame_valid = r_fv;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg7_ca_scan_reader.sv
module tb_seg7_ca_scan_reader;

  localparam int STABLE  = 8;
  localparam int TIMEOUT = 100;

  logic        clk;
  logic        reset;
  logic [6:0]  Segments;
  logic        dp;
  logic [3:0]  SEL;
  logic [15:0] BCD_out;
  logic [3:0]  dp_out;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;
  logic        stale;

  seg7_ca_scan_reader #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Segments   (Segments),
    .dp         (dp),
    .SEL        (SEL),
    .BCD_out    (BCD_out),
    .dp_out     (dp_out),
    .blank      (blank),
    .err        (err),
    .frame_valid(frame_valid),
    .stale      (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000,
                         P9 = 7'b0010000, PBLANK = 7'b1111111, PA = 7'b0001000;

  // ---------------- behavioural model ----------------
  logic [6:0]  pat [16];
  int          npat;
  logic [6:0]  hexpat [6];

  logic [11:0] m_s1 = '0, m_s2 = '0, m_run_val = '0;
  int          m_run_len = 0;
  int          m_since = 0;
  int          m_val [4];
  bit          m_dp [4], m_bl [4], m_er [4];
  bit [3:0]    m_present = '0;
  logic [15:0] e_bcd = '0;
  logic [3:0]  e_dp = '0, e_blank = '0, e_err = '0;
  logic        e_fv = 1'b0, e_stale = 1'b0;

  initial begin
    pat[0] = P0; pat[1] = P1; pat[2] = P2; pat[3] = P3; pat[4] = P4;
    pat[5] = P5; pat[6] = P6; pat[7] = P7; pat[8] = P8; pat[9] = P9;
    hexpat[0] = 7'b0001000; hexpat[1] = 7'b0000011; hexpat[2] = 7'b1000110;
    hexpat[3] = 7'b0100001; hexpat[4] = 7'b0000110; hexpat[5] = 7'b0001110;
    npat = 10;
`ifdef SEG7_READER_HEX_DECODE_EN
    for (int i = 0; i < 6; i++) pat[10 + i] = hexpat[i];
    npat = 16;
`endif
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0; m_dp[i] = 0; m_bl[i] = 0; m_er[i] = 0;
    end
  end

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_run_val = '0; m_run_len = 0; m_since = 0;
    m_present = '0;
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0; m_dp[i] = 0; m_bl[i] = 0; m_er[i] = 0;
    end
    e_bcd = '0; e_dp = '0; e_blank = '0; e_err = '0; e_fv = 1'b0; e_stale = 1'b0;
  endtask

  task automatic model_step();
    logic [11:0] s;
    bit          legal;
    int          d, v;
    bit          bl, er;
    s     = m_s2;
    legal = ($countones(s[11:8]) == 3);
    if (legal) begin
      if (m_run_len > 0 && s == m_run_val) m_run_len++;
      else begin
        m_run_val = s;
        m_run_len = 1;
      end
    end else begin
      m_run_len = 0;
    end
    e_fv = 1'b0;
    if (legal && m_run_len == STABLE) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!s[8 + i]) d = i;
      v = 15; bl = 0; er = 1;
      for (int i = 0; i < npat; i++) if (s[6:0] == pat[i]) begin v = i; er = 0; end
      if (s[6:0] == 7'h7F) begin v = 15; bl = 1; er = 0; end
      m_val[d] = v; m_dp[d] = !s[7]; m_bl[d] = bl; m_er[d] = er;
      m_present[d] = 1'b1;
      if (m_present == 4'b1111) begin
        e_bcd   = 16'(m_val[3] * 4096 + m_val[2] * 256 + m_val[1] * 16 + m_val[0]);
        e_dp    = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
        e_blank = {m_bl[3], m_bl[2], m_bl[1], m_bl[0]};
        e_err   = {m_er[3], m_er[2], m_er[1], m_er[0]};
        e_fv    = 1'b1;
        m_present = '0;
      end
      m_since = 0;
      e_stale = 1'b0;
    end else begin
      m_since++;
      if (m_since == TIMEOUT) begin
        e_stale   = 1'b1;
        m_present = '0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {SEL, dp, Segments};
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        checks++;
        if ({BCD_out, dp_out, blank, err, frame_valid, stale} !==
            {e_bcd, e_dp, e_blank, e_err, e_fv, e_stale}) begin
          failures++;
          $display("FAIL per_cycle t=%0t got bcd=%h dp=%b blank=%b err=%b fv=%b stale=%b want bcd=%h dp=%b blank=%b err=%b fv=%b stale=%b",
                   $time, BCD_out, dp_out, blank, err, frame_valid, stale,
                   e_bcd, e_dp, e_blank, e_err, e_fv, e_stale);
        end
        if (frame_valid) fv_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic show(input int d, input logic [6:0] seg, input bit dpon, input int n,
                      output int fv_at);
    logic [3:0] one;
    one      = 4'b0001 << d;
    SEL      = ~one;
    Segments = seg;
    dp       = ~dpon;
    fv_at    = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (frame_valid && fv_at == 0) fv_at = i;
    end
  endtask

  task automatic idle_pins(input logic [3:0] sel_v, input int n);
    SEL = sel_v; Segments = 7'h7F; dp = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                       input logic [6:0] s0, input logic [3:0] dpm, input int hold,
                       input int last_hold, input bit ghost, output int fv_last);
    logic [6:0] segs [4];
    int f;
    segs[3] = s3; segs[2] = s2; segs[1] = s1; segs[0] = s0;
    f = 0;
    for (int d = 3; d >= 0; d--) begin
      if (ghost) show(d, 7'b0000000, 1'b0, 3, f);
      show(d, segs[d], dpm[d], (d == 0) ? last_hold : hold, f);
    end
    fv_last = f;
  endtask

  int f, k_hit;
  logic [3:0]  rsel;
  logic [6:0]  rseg;
  int          rd;

  initial begin
    reset = 1'b1; SEL = 4'hF; dp = 1'b1; Segments = 7'h7F;
    repeat (3) @(negedge clk);
    #2;
    check_eq("reset_bcd", 32'(BCD_out), 32'h0);
    check_eq("reset_flags", 32'({dp_out, blank, err, frame_valid, stale}), 32'h0);
    reset = 1'b0;
    idle_pins(4'hF, 5);

    // clean scan "1234", dp on digit 2
    scan4(P1, P2, P3, P4, 4'b0100, 20, 20, 1'b0, f);
    #2;
    check_eq("clean_latency", 32'(f), 32'(STABLE + 2));
    check_eq("clean_fv_cnt", 32'(fv_cnt), 32'd1);
    check_eq("clean_bcd", 32'(BCD_out), 32'h1234);
    check_eq("clean_dp", 32'(dp_out), 32'b0100);
    check_eq("clean_err_blank", 32'({err, blank}), 32'h0);

    // ghosting at every digit switch
    scan4(P1, P2, P3, P4, 4'b0100, 20, 20, 1'b1, f);
    scan4(P1, P2, P3, P4, 4'b0100, 20, 20, 1'b1, f);
    #2;
    check_eq("ghost_fv_cnt", 32'(fv_cnt), 32'd3);
    check_eq("ghost_bcd", 32'(BCD_out), 32'h1234);

    // illegal selects
    idle_pins(4'b1111, 30);
    SEL = 4'b0000; Segments = P8; dp = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    check_eq("illegal_fv_cnt", 32'(fv_cnt), 32'd3);
    check_eq("illegal_bcd_hold", 32'(BCD_out), 32'h1234);
    scan4(P5, P6, P7, P8, 4'b0001, 20, 20, 1'b0, f);
    #2;
    check_eq("after_illegal_fv_cnt", 32'(fv_cnt), 32'd4);
    check_eq("after_illegal_bcd", 32'(BCD_out), 32'h5678);
    check_eq("after_illegal_dp", 32'(dp_out), 32'b0001);

    // error and blank
    scan4(P1, P2, PBLANK, PA, 4'b0000, 20, 20, 1'b0, f);
    #2;
    check_eq("eb_fv_cnt", 32'(fv_cnt), 32'd5);
    check_eq("eb_blank", 32'(blank), 32'b0010);
    check_eq("eb_bcd_hi", 32'(BCD_out[15:8]), 32'h12);
`ifdef SEG7_READER_HEX_DECODE_EN
    check_eq("eb_err", 32'(err), 32'b0000);
    check_eq("eb_bcd_lo", 32'(BCD_out[7:0]), 32'hFA);
`else
    check_eq("eb_err", 32'(err), 32'b0001);
    check_eq("eb_bcd_lo", 32'(BCD_out[7:0]), 32'hFF);
`endif

    // timeout
    scan4(P1, P2, P3, P4, 4'b0000, 20, STABLE + 2, 1'b0, f);
    check_eq("to_frame_latency", 32'(f), 32'(STABLE + 2));
    SEL = 4'b1111; Segments = 7'h7F; dp = 1'b1;
    k_hit = 0;
    for (int k = 1; k <= 2 * TIMEOUT; k++) begin
      @(negedge clk);
      if (stale && k_hit == 0) k_hit = k;
    end
    #2;
    check_eq("to_stale_delay", 32'(k_hit), 32'(TIMEOUT));
    check_eq("to_bcd_hold", 32'(BCD_out), 32'h1234);
    show(3, P9, 1'b0, 20, f);
    #2;
    check_eq("to_stale_cleared", 32'(stale), 32'd0);
    show(2, P8, 1'b0, 20, f);
    idle_pins(4'b1111, TIMEOUT + 10);
    #2;
    check_eq("to_stale_again", 32'(stale), 32'd1);
    show(1, P7, 1'b0, 20, f);
    show(0, P6, 1'b0, 20, f);
    #2;
    check_eq("to_partial_no_fv", 32'(fv_cnt), 32'd6);
    show(3, P5, 1'b0, 20, f);
    show(2, P4, 1'b0, 20, f);
    #2;
    check_eq("to_full_fv", 32'(fv_cnt), 32'd7);
    check_eq("to_full_bcd", 32'(BCD_out), 32'h5476);

    // async reset two cycles into qualifying digit 3
    show(3, P1, 1'b0, 4, f);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_bcd", 32'(BCD_out), 32'h0);
    check_eq("rst_flags", 32'({dp_out, blank, err, frame_valid, stale}), 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    show(2, P2, 1'b0, 20, f);
    show(1, P3, 1'b0, 20, f);
    show(0, P4, 1'b0, 20, f);
    #2;
    check_eq("rst_no_fv", 32'(fv_cnt), 32'd7);
    show(3, P1, 1'b0, 20, f);
    #2;
    check_eq("rst_new_fv", 32'(fv_cnt), 32'd8);
    check_eq("rst_new_bcd", 32'(BCD_out), 32'h1234);

    // randomized scanning, glitches, illegal selects and long stalls
    rd = 3;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0:       rseg = 7'($urandom);
        1:       rseg = hexpat[$urandom_range(0, 5)];
        2:       rseg = PBLANK;
        default: rseg = pat[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 11) == 0) begin
        rsel = 4'($urandom);
        SEL = rsel; Segments = rseg; dp = 1'($urandom);
        repeat ($urandom_range(1, 12)) @(negedge clk);
      end else if ($urandom_range(0, 59) == 0) begin
        idle_pins(4'b1111, TIMEOUT + $urandom_range(0, 20));
      end else begin
        show(rd, rseg, 1'($urandom), $urandom_range(1, 24), f);
        rd = (rd == 0) ? 3 : rd - 1;
      end
    end
    repeat (5) @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
